// File: rtl/rob.sv
// Reorder buffer between execution and writeback.
// Dispatch allocates entries in program order. Execution units complete them
// out of order by tag. Writeback retires a contiguous group of done entries
// from the head through the consume / consume_count handshake.

package pipTypes;
    typedef struct packed {
        logic [4:0]  dest_reg;
        logic        dest_reg_valid;
        logic [31:0] result_lo;
        logic [31:0] result_hi;
    } rob_entry_t;
endpackage

module rob
    import pipTypes::*;
#(
    parameter int DEPTH        = 16,
    parameter int RETIRE_COUNT = 4,
    parameter int WB_PORTS     = 2,
    parameter int COUNT_WIDTH  = $clog2(RETIRE_COUNT),
    parameter int TAG_W        = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   alloc_valid,
    input  rob_entry_t             alloc_data,
    output logic                   alloc_ready,
    output logic [TAG_W-1:0]       alloc_tag,
    input  logic [WB_PORTS-1:0]    wr_valid,
    input  logic [TAG_W-1:0]       wr_tag       [WB_PORTS],
    input  logic [31:0]            wr_result_lo [WB_PORTS],
    input  logic [31:0]            wr_result_hi [WB_PORTS],
    input  logic                   consume,
    input  logic [COUNT_WIDTH-1:0] consume_count,
    output rob_entry_t             slot_data    [RETIRE_COUNT],
    output logic [RETIRE_COUNT-1:0] slot_valid,
    output logic                   empty
);

    rob_entry_t         storage [DEPTH];
    logic [DEPTH-1:0]   occ;
    logic [DEPTH-1:0]   done;
    logic [TAG_W-1:0]   head;
    logic [TAG_W-1:0]   tail;
    logic [TAG_W:0]     count;

    logic               alloc_fire;
    logic [COUNT_WIDTH:0] retire_n;
    logic [TAG_W:0]     count_inc;
    logic [TAG_W:0]     count_dec;
    logic [COUNT_WIDTH:0] valid_cnt;

    // Space is judged on registered count only, so a same-cycle retirement
    // never frees a slot early.
    assign alloc_ready = (count != (TAG_W+1)'(DEPTH));
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_tag   = tail;
    assign empty       = (count == '0);
    assign retire_n    = (COUNT_WIDTH+1)'(consume_count) + (COUNT_WIDTH+1)'(1);
    assign count_inc   = (TAG_W+1)'(alloc_fire);
    assign count_dec   = consume ? (TAG_W+1)'(retire_n) : '0;

    // Head window: present the oldest entries and their contiguous done prefix.
    always_comb begin
        logic run;
        // NOTE: every output of this block is assigned a default before any
        // conditional logic, so no latch can be inferred.
        run       = 1'b1;
        valid_cnt = '0;
        for (int i = 0; i < RETIRE_COUNT; i++) begin
            slot_data[i]  = storage[head + TAG_W'(i)];
            run           = run & occ[head + TAG_W'(i)] & done[head + TAG_W'(i)];
            slot_valid[i] = run;
            valid_cnt     = valid_cnt + (COUNT_WIDTH+1)'(run);
        end
    end

    // Entry payload: allocation writes the whole entry, completions overwrite
    // the results; the higher port index is written last and so wins.
    // NOTE: the payload array has no reset; occ/done qualify every use of it.
    always_ff @(posedge clock) begin
        if (!flush) begin
            if (alloc_fire) begin
                storage[tail] <= alloc_data;
            end
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wr_valid[p] && occ[wr_tag[p]]) begin
                    storage[wr_tag[p]].result_lo <= wr_result_lo[p];
                    storage[wr_tag[p]].result_hi <= wr_result_hi[p];
                end
            end
        end
    end

    // Occupancy and completion bits: set on allocate / complete, cleared on
    // retirement; retirement is applied last so it wins on its own entries.
    // NOTE: sequential state uses non-blocking assignments only, so later
    // assignments in this block override earlier ones for the same bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            occ  <= '0;
            done <= '0;
        end else if (flush) begin
            occ  <= '0;
            done <= '0;
        end else begin
            if (alloc_fire) begin
                occ[tail]  <= 1'b1;
                done[tail] <= 1'b0;
            end
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wr_valid[p] && occ[wr_tag[p]]) begin
                    done[wr_tag[p]] <= 1'b1;
                end
            end
            if (consume) begin
                for (int i = 0; i < RETIRE_COUNT; i++) begin
                    if (COUNT_WIDTH'(i) <= consume_count) begin
                        occ[head + TAG_W'(i)]  <= 1'b0;
                        done[head + TAG_W'(i)] <= 1'b0;
                    end
                end
            end
        end
    end

    // Pointers and occupancy count; pointers wrap naturally at TAG_W bits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire) begin
                tail <= tail + TAG_W'(1);
            end
            if (consume) begin
                head <= head + TAG_W'(retire_n);
            end
            count <= count + count_inc - count_dec;
        end
    end

    // Writeback may only retire entries that are shown as retirable.
    consume_needs_head: assert property (@(posedge clock) disable iff (!reset_n || flush)
        consume |-> slot_valid[0]);
    consume_within_valid: assert property (@(posedge clock) disable iff (!reset_n || flush)
        consume |-> (retire_n <= valid_cnt));

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed scenarios plus randomized traffic,
// all compared against a program-order queue model of the buffer.

module tb_rob;
    import pipTypes::*;

    localparam int DEPTH = 16;
    localparam int RC    = 4;
    localparam int WP    = 2;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush;
    logic             alloc_valid;
    rob_entry_t       alloc_data;
    logic             alloc_ready;
    logic [3:0]       alloc_tag;
    logic [WP-1:0]    wr_valid;
    logic [3:0]       wr_tag       [WP];
    logic [31:0]      wr_result_lo [WP];
    logic [31:0]      wr_result_hi [WP];
    logic             consume;
    logic [1:0]       consume_count;
    rob_entry_t       slot_data    [RC];
    logic [RC-1:0]    slot_valid;
    logic             empty;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    rob dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_data(alloc_data),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wr_valid(wr_valid), .wr_tag(wr_tag),
        .wr_result_lo(wr_result_lo), .wr_result_hi(wr_result_hi),
        .consume(consume), .consume_count(consume_count),
        .slot_data(slot_data), .slot_valid(slot_valid), .empty(empty)
    );

    // Reference model: entries in program order, oldest first.
    typedef struct {
        logic [3:0] tag;
        rob_entry_t e;
        bit         done;
    } m_t;
    m_t         mq [$];
    logic [3:0] next_tag = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic rob_entry_t rand_entry();
        rob_entry_t e;
        e.dest_reg       = 5'($urandom);
        e.dest_reg_valid = 1'($urandom);
        e.result_lo      = $urandom;
        e.result_hi      = $urandom;
        return e;
    endfunction

    function automatic int model_valid_cnt();
        int n = 0;
        for (int i = 0; i < RC && i < mq.size(); i++) begin
            if (!mq[i].done) break;
            n++;
        end
        return n;
    endfunction

    task automatic idle();
        flush = 0; alloc_valid = 0; alloc_data = '0; consume = 0; consume_count = 0;
        wr_valid = '0;
        for (int p = 0; p < WP; p++) begin
            wr_tag[p] = '0; wr_result_lo[p] = '0; wr_result_hi[p] = '0;
        end
    endtask

    // Apply the current inputs to the model as one clock edge.
    task automatic model_step();
        bit had_room;
        if (flush) begin
            mq.delete();
            next_tag = '0;
            return;
        end
        had_room = (mq.size() != DEPTH);
        for (int p = 0; p < WP; p++) begin
            if (wr_valid[p]) begin
                for (int j = 0; j < mq.size(); j++) begin
                    if (mq[j].tag == wr_tag[p]) begin
                        mq[j].e.result_lo = wr_result_lo[p];
                        mq[j].e.result_hi = wr_result_hi[p];
                        mq[j].done = 1;
                    end
                end
            end
        end
        if (consume) begin
            for (int i = 0; i <= int'(consume_count); i++) begin
                if (mq.size() > 0) void'(mq.pop_front());
            end
        end
        if (alloc_valid && had_room) begin
            m_t m;
            m.tag = next_tag; m.e = alloc_data; m.done = 0;
            mq.push_back(m);
            next_tag = next_tag + 4'd1;
        end
    endtask

    task automatic compare_all();
        logic [RC-1:0] exp_sv;
        bit run = 1;
        check("empty", 128'(empty), 128'(mq.size() == 0));
        check("alloc_ready", 128'(alloc_ready), 128'(mq.size() != DEPTH));
        check("alloc_tag", 128'(alloc_tag), 128'(next_tag));
        for (int i = 0; i < RC; i++) begin
            run = run && (i < mq.size()) && mq[i].done;
            exp_sv[i] = run;
        end
        check("slot_valid", 128'(slot_valid), 128'(exp_sv));
        for (int i = 0; i < RC && i < mq.size(); i++) begin
            check($sformatf("slot_data%0d", i), 128'(slot_data[i]), 128'(mq[i].e));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        idle();
        compare_all();
    endtask

    // Asynchronous reset in the middle of a cycle; state must clear at once.
    task automatic do_reset();
        @(negedge clock);
        idle();
        #2 reset_n = 0;
        #1;
        check("rst_empty", 128'(empty), 128'(1));
        check("rst_ready", 128'(alloc_ready), 128'(1));
        check("rst_tag", 128'(alloc_tag), 128'(0));
        check("rst_slot_valid", 128'(slot_valid), 128'(0));
        mq.delete();
        next_tag = '0;
        @(negedge clock);
        reset_n = 1;
        #1 compare_all();
    endtask

    task automatic alloc_one();
        alloc_valid = 1;
        alloc_data  = rand_entry();
        tick();
    endtask

    task automatic complete2(input int t0, input int t1);
        wr_valid = 2'b11;
        wr_tag[0] = 4'(t0); wr_result_lo[0] = $urandom; wr_result_hi[0] = $urandom;
        wr_tag[1] = 4'(t1); wr_result_lo[1] = $urandom; wr_result_hi[1] = $urandom;
        tick();
    endtask

    task automatic retire(input int n);
        consume = 1;
        consume_count = 2'(n - 1);
        tick();
    endtask

    initial begin
        rob_entry_t saved [4];
        idle();
        #12 reset_n = 1;
        @(negedge clock);
        compare_all();

        // Out-of-order completion: nothing retirable until the head is done.
        do_reset();
        repeat (3) alloc_one();
        wr_valid = 2'b01; wr_tag[0] = 4'd1; wr_result_lo[0] = $urandom; wr_result_hi[0] = $urandom;
        tick();
        check("tp_only_tag1", 128'(slot_valid), 128'(4'b0000));
        wr_valid = 2'b01; wr_tag[0] = 4'd0; wr_result_lo[0] = $urandom; wr_result_hi[0] = $urandom;
        tick();
        check("tp_tag0_tag1", 128'(slot_valid), 128'(4'b0011));
        retire(2);
        check("tp_after_retire_empty", 128'(empty), 128'(0));
        check("tp_after_retire_sv", 128'(slot_valid), 128'(4'b0000));

        // Full buffer: allocation refused in the same cycle as a retirement.
        do_reset();
        repeat (16) alloc_one();
        check("full_ready", 128'(alloc_ready), 128'(0));
        for (int t = 0; t < 16; t += 2) complete2(t, t + 1);
        check("full_sv", 128'(slot_valid), 128'(4'b1111));
        alloc_valid = 1; alloc_data = rand_entry();
        retire(4);
        check("full_ready_after", 128'(alloc_ready), 128'(1));
        check("full_tag_after", 128'(alloc_tag), 128'(0));

        // Wrap-around of head window across entry 15 -> 0.
        do_reset();
        repeat (14) alloc_one();
        for (int t = 0; t < 14; t += 2) complete2(t, t + 1);
        retire(4); retire(4); retire(4); retire(2);
        for (int i = 0; i < 4; i++) begin
            saved[i] = rand_entry();
            alloc_valid = 1; alloc_data = saved[i];
            tick();
        end
        complete2(14, 15);
        complete2(0, 1);
        check("wrap_sv", 128'(slot_valid), 128'(4'b1111));
        check("wrap_slot2_dest", 128'(slot_data[2].dest_reg), 128'(saved[2].dest_reg));
        retire(4);
        check("wrap_empty", 128'(empty), 128'(1));
        check("wrap_tag", 128'(alloc_tag), 128'(2));

        // Two ports on one tag, and a write to an unoccupied tag.
        do_reset();
        repeat (6) alloc_one();
        wr_valid = 2'b11;
        wr_tag[0] = 4'd5; wr_result_lo[0] = 32'hAAAA; wr_result_hi[0] = 32'h1;
        wr_tag[1] = 4'd5; wr_result_lo[1] = 32'hBBBB; wr_result_hi[1] = 32'h2;
        tick();
        complete2(0, 1);
        complete2(2, 3);
        complete2(4, 4);
        retire(2);
        check("dup_lo", 128'(slot_data[3].result_lo), 128'(32'hBBBB));
        check("dup_hi", 128'(slot_data[3].result_hi), 128'(32'h2));
        wr_valid = 2'b01; wr_tag[0] = 4'd9; wr_result_lo[0] = $urandom; wr_result_hi[0] = $urandom;
        tick();
        repeat (4) alloc_one();
        complete2(6, 7);
        complete2(8, 8);
        retire(4);
        check("unocc_tag9", 128'(slot_valid), 128'(4'b0111));

        // Flush overrides allocate, complete and consume together.
        flush = 1; alloc_valid = 1; alloc_data = rand_entry();
        wr_valid = 2'b11; wr_tag[0] = 4'd9; wr_tag[1] = 4'd6;
        consume = 1; consume_count = 2'd2;
        tick();
        check("flush_empty", 128'(empty), 128'(1));
        check("flush_tag", 128'(alloc_tag), 128'(0));
        check("flush_sv", 128'(slot_valid), 128'(4'b0000));

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            int vc;
            flush = ($urandom_range(0, 99) == 0);
            alloc_valid = ($urandom_range(0, 9) < 7);
            alloc_data  = rand_entry();
            for (int p = 0; p < WP; p++) begin
                wr_valid[p] = 1'($urandom);
                if (mq.size() > 0 && $urandom_range(0, 4) != 0)
                    wr_tag[p] = mq[$urandom_range(0, mq.size() - 1)].tag;
                else
                    wr_tag[p] = 4'($urandom);
                wr_result_lo[p] = $urandom;
                wr_result_hi[p] = $urandom;
            end
            vc = model_valid_cnt();
            if (vc > 0 && $urandom_range(0, 2) != 0) begin
                consume = 1;
                consume_count = 2'($urandom_range(0, vc - 1));
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
